// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART transmitter: register offsets,
// CR/SR bit positions and the transmit FSM state encoding.
package uart_pkg;

  localparam int unsigned BRR_W = 16;
  localparam int unsigned DATA_W = 8;

  // Register word offsets, decoded from PADDR[3:2]
  localparam logic [1:0] REG_CR  = 2'd0;
  localparam logic [1:0] REG_SR  = 2'd1;
  localparam logic [1:0] REG_TDR = 2'd2;
  localparam logic [1:0] REG_BRR = 2'd3;

  localparam int unsigned CR_EN  = 0;
  localparam int unsigned CR_PEN = 1;

  localparam int unsigned SR_FULL  = 0;
  localparam int unsigned SR_EMPTY = 1;
  localparam int unsigned SR_BUSY  = 2;
  localparam int unsigned SR_OVR   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO; a push on a full FIFO is accepted only when a
// pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; empty/full come from the counter
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_uart_tx.sv
// APB-programmed UART transmitter with a TX FIFO and programmable baud divisor.
// Define UART_TX_PARITY_EN to add the even-parity bit (CR.PEN, PARITY state).
module apb_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BRR_RST    = 32'd433
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx,
  output logic        tx_irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              en_q, ovr_q;
  logic [BRR_W-1:0]  brr_q;
  logic              wr_acc, cr_wr, sr_wr, tdr_wr, brr_wr;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic [3:0]        sr;
  logic              busy, ovr_set, launch, bit_end, frame_go;
  logic              unused_bits;

  tx_state_e         state_q, state_d;
  logic [BRR_W-1:0]  baud_q, baud_d, div_q, div_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic              pen_q, pen_lat_q, pen_lat_d, par_q, par_d;
`endif

  assign PREADY = PSEL & PENABLE;
  assign wr_acc = PSEL & PENABLE & PWRITE;
  assign cr_wr  = wr_acc & (PADDR[3:2] == REG_CR);
  assign sr_wr  = wr_acc & (PADDR[3:2] == REG_SR);
  assign tdr_wr = wr_acc & (PADDR[3:2] == REG_TDR);
  assign brr_wr = wr_acc & (PADDR[3:2] == REG_BRR);

  assign unused_bits = ^{PADDR[1:0], PWDATA[31:16], fifo_count};

  assign busy      = (state_q != ST_IDLE);
  assign fifo_push = tdr_wr;
  assign ovr_set   = tdr_wr & fifo_full & ~fifo_pop;
  assign tx        = tx_q;
  assign tx_irq    = en_q & fifo_empty & ~busy;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (PCLK),
    .rst_n   (PRESET),
    .push_i  (fifo_push),
    .wdata_i (PWDATA[DATA_W-1:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    sr           = '0;
    sr[SR_FULL]  = fifo_full;
    sr[SR_EMPTY] = fifo_empty;
    sr[SR_BUSY]  = busy;
    sr[SR_OVR]   = ovr_q;
  end

  // Read mux follows PADDR directly; TDR and unused bits read as zero
  always_comb begin
    PRDATA = '0;
    case (PADDR[3:2])
      REG_CR: begin
        PRDATA[CR_EN] = en_q;
`ifdef UART_TX_PARITY_EN
        PRDATA[CR_PEN] = pen_q;
`endif
      end
      REG_SR:  PRDATA[3:0] = sr;
      REG_BRR: PRDATA[BRR_W-1:0] = brr_q;
      default: PRDATA = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      en_q  <= 1'b0;
      ovr_q <= 1'b0;
      brr_q <= BRR_RST[BRR_W-1:0];
`ifdef UART_TX_PARITY_EN
      pen_q <= 1'b0;
`endif
    end else begin
      if (cr_wr) begin
        en_q <= PWDATA[CR_EN];
`ifdef UART_TX_PARITY_EN
        pen_q <= PWDATA[CR_PEN];
`endif
      end
      if (brr_wr) brr_q <= PWDATA[BRR_W-1:0];
      if (ovr_set) ovr_q <= 1'b1;
      else if (sr_wr && PWDATA[SR_OVR]) ovr_q <= 1'b0;
    end
  end

  assign frame_go = en_q & ~fifo_empty;
  assign bit_end  = (baud_q == div_q);

  // Next-state logic; tx_d is the line level for the state being entered
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    launch   = 1'b0;
`ifdef UART_TX_PARITY_EN
    pen_lat_d = pen_lat_q;
    par_d     = par_q;
`endif

    if (busy) baud_d = bit_end ? '0 : baud_q + BRR_W'(1);

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (frame_go) launch = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (pen_lat_q) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (frame_go) launch = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame launch: pop a byte and freeze divisor/parity mode for this frame
    if (launch) begin
      fifo_pop = 1'b1;
      state_d  = ST_START;
      tx_d     = 1'b0;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = fifo_rdata;
      div_d    = (brr_q == '0) ? BRR_W'(1) : brr_q;
`ifdef UART_TX_PARITY_EN
      pen_lat_d = pen_q;
      par_d     = even_parity(fifo_rdata);
`endif
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      div_q   <= BRR_W'(1);
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      pen_lat_q <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      pen_lat_q <= pen_lat_d;
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: doc/apb_uart_tx.md
APB_UART_TX -- requirements
Module: apb_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of TX FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter BRR_RST, default 32'd433, reset value of the baud divisor register.
REQ-003 SHALL have port PCLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port PRESET  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port PADDR  input  4  register byte address; bits [3:2] decode, bits [1:0] ignored.
REQ-006 SHALL have ports PWRITE, PSEL, PENABLE  input  1 each  APB control.
REQ-007 SHALL have port PWDATA  input  32  write data.
REQ-008 SHALL have port PRDATA  output  32  read data.
REQ-009 SHALL have port PREADY  output  1  transfer complete.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port tx_irq  output  1  level interrupt: CR.EN & SR.EMPTY & ~SR.BUSY.

Function
REQ-012 SHALL have register map: 0x0 CR (bit0 EN, bit1 PEN), 0x4 SR (read-only except W1C), 0x8 TDR (write-only, bits[7:0]), 0xC BRR (bits[15:0]).
REQ-013 SHALL drive PREADY = PSEL & PENABLE (zero wait states); SHALL perform writes only in the access cycle (PSEL & PENABLE & PWRITE).
REQ-014 SHALL drive PRDATA combinationally from the PADDR decode; unused bits read 0; TDR reads 0.
REQ-015 SHALL assign SR bits: bit0 FULL, bit1 EMPTY, bit2 BUSY (FSM not IDLE), bit3 OVR (sticky); writing 1 to SR bit3 SHALL clear OVR.
REQ-016 SHALL push PWDATA[7:0] into the FIFO on a TDR write when the FIFO is not full; a TDR write while full SHALL be dropped and set OVR.
REQ-017 SHALL, when a push and a pop occur in the same cycle on a full FIFO, accept both and leave the count unchanged, with OVR unchanged.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; the bit period is BRR+1 PCLK cycles; a BRR value of 0 SHALL behave as 1.
REQ-019 SHALL go from IDLE to START in the cycle after CR.EN=1 & ~EMPTY is sampled, popping one byte on that transition.
REQ-020 SHALL hold tx=0 for one bit period in START, then send DATA as 8 bits LSB first with one bit period each.
REQ-021 SHALL go from DATA to PARITY only when the parity feature is present (REQ-029) and CR.PEN=1; otherwise from DATA to STOP.
REQ-022 SHALL hold tx=1 for one bit period in STOP, then go to START if EN & ~EMPTY, else to IDLE, so back-to-back frames have no idle gap.
REQ-023 SHALL let a frame in progress complete when CR.EN is cleared mid-frame; no new frame SHALL start afterwards.
REQ-024 SHALL sample BRR and PEN at the START transition; writes to them mid-frame SHALL affect only the next frame.

Reset
REQ-025 SHALL, on PRESET low, immediately set tx=1, FSM=IDLE, FIFO empty, CR=0, OVR=0, BRR=BRR_RST[15:0], and clear the baud and bit counters.
REQ-026 SHALL have reset output values PRDATA=0, PREADY=0, tx_irq=0, with SR reading 0x2; a frame aborted by reset SHALL NOT resume.

Configuration
REQ-027 SHALL provide the macro UART_TX_PARITY_EN; when defined, the PARITY state and CR.PEN are implemented.
REQ-028 SHALL, with the macro defined and PEN=1, send the PARITY bit as the even parity of the 8 data bits, for one bit period.
REQ-029 SHALL, without the macro, omit the PARITY state, make CR bit1 read 0 and ignore writes to it, and always send 10-bit frames.

Structure
REQ-030 SHALL place register offsets, the CR/SR bit indices, and the FSM state enum in the shared package uart_pkg.
REQ-031 SHALL implement the FIFO as the sub-module uart_tx_fifo (push/pop/full/empty/count), instantiated once.

Verification
REQ-032 SHALL check: after reset, read SR -> 0x2; read BRR -> 0x1B1; tx=1; tx_irq=0.
REQ-033 SHALL check: BRR=3, CR=1, TDR=0x55 -> tx low 4 cycles, then data 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; 40 cycles total; BUSY=1 throughout.
REQ-034 SHALL check: CR=0, five TDR writes 0x01..0x05 -> SR=0x9 (FULL|OVR), 0x05 lost; write SR=0x8 -> OVR cleared; CR=1 -> frames 0x01..0x04 sent back-to-back with no gap.
REQ-035 SHALL check: PRESET low mid-DATA of 0xA3 -> tx=1 the same cycle; after release, SR=0x2 and no frame is resumed.
REQ-036 SHALL check: with UART_TX_PARITY_EN, CR=0x3, TDR=0x07 -> parity bit 1 and 11-bit frame; without the macro, CR write 0x3 reads back 0x1.
REQ-037 SHALL check: CR cleared during frame 1 of 2 queued -> frame 1 completes, frame 2 stays queued, SR=0x0.
